instr_fetch_seq: RTL

- Instruction fetch/issue sequencer: the producer end of the 5-bit opcode interface consumed by the control unit.
- Holds the PC, reads instruction memory and presents {opcode, operand} with a valid flag.
- Applies branch/jump redirects using the branch/jump indication and the datapath's taken/target result.
- Sits between the instruction memory and the decode/control stage of the single-issue core.

---
 rtl/instr_fetch_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: PC, imem read, {opcode, operand} issue and branch redirect.
// Build option FETCH_PERF_CNT_EN adds a saturating retired-instruction counter (retired_cnt).
module instr_fetch_seq #(
  parameter int          PC_WIDTH   = 10,
  parameter int          OPND_WIDTH = 4,
  parameter logic [4:0]  HALT_OP    = 5'b11111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    imem_rd,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [4+OPND_WIDTH:0]   imem_data,
  input  logic                    stall,
  input  logic                    br_or_jump,
  input  logic                    br_taken,
  input  logic [PC_WIDTH-1:0]     br_target,
  output logic [4:0]              opcode,
  output logic [OPND_WIDTH-1:0]   operand,
  output logic                    instr_valid,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]             retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                  state_reg, state_next;
  logic [PC_WIDTH-1:0]     pc_reg, pc_next;
  logic [4:0]              opcode_reg, opcode_next;
  logic [OPND_WIDTH-1:0]   operand_reg, operand_next;
  logic                    halted_reg, halted_next;
  logic                    retire;
  logic                    start_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      opcode_reg  <= '0;
      operand_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      halted_reg  <= halted_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    halted_next  = halted_reg;
    retire       = 1'b0;
    start_ack    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_ack  = 1'b1;
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        // Memory data lands one cycle after the read strobe, i.e. during this state.
        opcode_next  = imem_data[OPND_WIDTH +: 5];
        operand_next = imem_data[OPND_WIDTH-1:0];
        state_next   = S_ISSUE;
      end
      S_ISSUE: begin
        if (!stall) begin
          if (opcode_reg == HALT_OP) begin
            halted_next = 1'b1;
            state_next  = S_HALT;
          end else begin
            retire     = 1'b1;
            state_next = S_FETCH;
            if (br_or_jump && br_taken) pc_next = br_target;
            else                        pc_next = pc_reg + PC_WIDTH'(1);
          end
        end
      end
      S_HALT: begin
        if (start) begin
          start_ack   = 1'b1;
          halted_next = 1'b0;
          pc_next     = '0;
          state_next  = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_rd     = (state_reg == S_FETCH);
  assign imem_addr   = pc_reg;
  assign instr_valid = (state_reg == S_ISSUE);
  assign opcode      = opcode_reg;
  assign operand     = operand_reg;
  assign pc          = pc_reg;
  assign halted      = halted_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || start_ack) retired_cnt_reg <= '0;
    else if (retire && (retired_cnt_reg != 16'hFFFF)) retired_cnt_reg <= retired_cnt_reg + 16'd1;
  end

  assign retired_cnt = retired_cnt_reg;
`else
  logic unused_start_ack;
  assign unused_start_ack = start_ack;
`endif

endmodule
